packet_disassembler: RTL
========================

Name: packet_disassembler

Overview:
- Sink-side counterpart of the source packet path.
- Takes TERC4-decoded data-island payload bits, one symbol per pixel clock. Reassembles each 32-clock HDMI packet into a 24-bit header and four 56-bit subpackets. Checks BCH parity on each.
- Sits between the TMDS/TERC4 decoders and the per-type packet consumers (InfoFrame parsers, audio sample/ACR decoders).
- Consumers dispatch on packet_type.

Parameters:
- DROP_BAD_HEADER, 0, when 1, packet_valid is suppressed for packets whose header ECC check fails.

Ports:
- clk_pixel  input  1  pixel clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_island_period  input  1  high exactly during packet payload clocks; guard bands excluded upstream.
- packet_data  input  9  decoded payload bits for this clock:
  - bit0: header bit (ch0 bit2).
  - bit(1+2k): subpacket k even bit (ch1 bit k).
  - bit(2+2k): subpacket k odd bit (ch2 bit k), k=0..3.
- header  output  24  last completed header, LSB first as received.
- sub  output  56 x [3:0]  last completed subpackets (logic [55:0] sub [3:0]).
- packet_type  output  8  header[7:0].
- header_ecc_ok  output  1  received header parity matches computed.
- sub_ecc_ok  output  4  per-subpacket parity match.
- packet_valid  output  1  one-cycle pulse when all outputs update.
- packet_abort  output  1  one-cycle pulse when a packet is truncated.

Behaviour:
- Reset values:
  - All outputs 0.
  - Bit counter 0.
  - Shift registers and LFSRs 0.
- Counter:
  - 5-bit, advances on each clock with data_island_period=1.
  - Wraps 31->0, so back-to-back packets within one island are framed every 32 clocks.
- Header assembly, counts 0..23:
  - packet_data[0] is a data bit, stored at header bit index=count.
  - It is also fed into the header BCH LFSR.
- Header parity, counts 24..31:
  - packet_data[0] is captured as received parity bit (count-24).
- Subpacket assembly, counts 0..27:
  - Bits 2c and 2c+1 of subpacket k are packet_data[1+2k] and packet_data[2+2k].
  - The LFSR consumes the even bit then the odd bit within the same cycle (two serial steps).
- Subpacket parity, counts 28..31:
  - Received parity bits 2(c-28) and 2(c-28)+1 are taken from the same positions.
- BCH code:
  - Generator x^8+x^7+x^6+1, 8-bit LFSR, init 0, LSB-first.
  - BCH(32,24) for the header, BCH(64,56) for subpackets.
  - The computed parity is the LFSR state after the last data bit.
- Completion (count 31 sampled with data_island_period=1):
  - On the next rising edge, header, sub, packet_type and ecc flags are registered.
  - packet_valid=1 for exactly one cycle, so latency is 1 clock after the final payload bit.
  - LFSRs and received-parity registers clear for the next packet.
- Outputs hold their values until the next completion; they are not cleared on abort.
- DROP_BAD_HEADER=1 with a header mismatch:
  - Outputs still update and header_ecc_ok=0.
  - packet_valid stays 0.
- Abort:
  - Condition: data_island_period falls while count!=0 (mid-packet).
  - packet_abort pulses 1 cycle on the following edge.
  - Counter, LFSRs and partial registers clear.
  - No packet_valid is issued.
- data_island_period low with count==0: idle, no pulse.
- Reset asserted mid-packet: everything returns to reset values on that edge and no pulse is issued. Reassembly restarts at count 0 on the first payload clock after reset deasserts.
- Simultaneous events:
  - reset has priority over completion and abort.
  - Completion of packet N and bit 0 of packet N+1 happen on the same edge without loss.

Test Plan:
- Null packet: 32 clocks of packet_data=0 -> one cycle later, packet_valid=1, header=0, sub all 0, header_ecc_ok=1, sub_ecc_ok=4'hF, packet_type=0.
- Known packet:
  - Stimulus: header 24'h000001 (ACR) with subpackets 56'h0018_0000_1000_00 each, parity from the bench reference BCH model.
  - Required: fields match bit-exactly and all ecc flags are 1.
- Corrupted parity:
  - Flip header parity bit 3 (count 27) -> header_ecc_ok=0.
  - Flip subpacket 2 data bit 10 -> sub_ecc_ok=4'b1011.
  - With DROP_BAD_HEADER=1, the header-flip case gives no packet_valid.
- Back-to-back: 64 continuous payload clocks carrying packet_type 8'h82 then 8'h84 -> packet_valid pulses exactly 32 clocks apart with correct types.
- Abort: deassert data_island_period at count 17 -> packet_abort pulses once, no packet_valid, outputs retain the prior packet. The next full packet decodes correctly.
- Reset at count 10 -> all outputs 0 next cycle, no pulses. The following 32-clock packet decodes correctly from count 0.

Source files
------------

// File: rtl/packet_disassembler.sv
// Sink-side HDMI data-island packet reassembly: frames 32-clock packets from TERC4-decoded
// payload bits into a header and four subpackets, checking BCH parity on each.
module packet_disassembler #(
    parameter bit DROP_BAD_HEADER = 1'b0
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        data_island_period,
    input  logic [8:0]  packet_data,
    output logic [23:0] header,
    output logic [55:0] sub [3:0],
    output logic [7:0]  packet_type,
    output logic        header_ecc_ok,
    output logic [3:0]  sub_ecc_ok,
    output logic        packet_valid,
    output logic        packet_abort
);

    // One serial step of the LSB-first x^8+x^7+x^6+1 LFSR (reflected taps 0x83).
    function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic bit_in);
        logic fb;
        fb = ecc[0] ^ bit_in;
        return (ecc >> 1) ^ (fb ? 8'h83 : 8'h00);
    endfunction

    logic [4:0]  cnt_q;
    logic [23:0] hdr_q,     hdr_d;
    logic [7:0]  hdr_par_q, hdr_par_d;
    logic [7:0]  hdr_ecc_q, hdr_ecc_d;
    logic [55:0] sub_q     [4];
    logic [55:0] sub_d     [4];
    logic [7:0]  sub_par_q [4];
    logic [7:0]  sub_par_d [4];
    logic [7:0]  sub_ecc_q [4];
    logic [7:0]  sub_ecc_d [4];
    logic        hdr_ok;
    logic [3:0]  sub_ok;

    always_comb begin
        hdr_d     = hdr_q;
        hdr_par_d = hdr_par_q;
        hdr_ecc_d = hdr_ecc_q;
        for (int k = 0; k < 4; k++) begin
            sub_d[k]     = sub_q[k];
            sub_par_d[k] = sub_par_q[k];
            sub_ecc_d[k] = sub_ecc_q[k];
        end

        if (cnt_q < 5'd24) begin
            hdr_d[cnt_q] = packet_data[0];
            hdr_ecc_d    = bch_step(hdr_ecc_q, packet_data[0]);
        end else begin
            hdr_par_d[cnt_q[2:0]] = packet_data[0];
        end

        // Even bit then odd bit: two LFSR steps per clock.
        for (int k = 0; k < 4; k++) begin
            if (cnt_q < 5'd28) begin
                sub_d[k][{cnt_q, 1'b0}] = packet_data[1 + 2 * k];
                sub_d[k][{cnt_q, 1'b1}] = packet_data[2 + 2 * k];
                sub_ecc_d[k] = bch_step(bch_step(sub_ecc_q[k], packet_data[1 + 2 * k]),
                                        packet_data[2 + 2 * k]);
            end else begin
                sub_par_d[k][{cnt_q[1:0], 1'b0}] = packet_data[1 + 2 * k];
                sub_par_d[k][{cnt_q[1:0], 1'b1}] = packet_data[2 + 2 * k];
            end
        end
    end

    // Parity comparisons include the final parity bits arriving on this clock.
    assign hdr_ok = (hdr_par_d == hdr_ecc_q);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub_ok
            assign sub_ok[gi] = (sub_par_d[gi] == sub_ecc_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cnt_q         <= '0;
            hdr_q         <= '0;
            hdr_par_q     <= '0;
            hdr_ecc_q     <= '0;
            header        <= '0;
            packet_type   <= '0;
            header_ecc_ok <= 1'b0;
            sub_ecc_ok    <= '0;
            packet_valid  <= 1'b0;
            packet_abort  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                sub_q[k]     <= '0;
                sub_par_q[k] <= '0;
                sub_ecc_q[k] <= '0;
                sub[k]       <= '0;
            end
        end else begin
            packet_valid <= 1'b0;
            packet_abort <= 1'b0;
            if (data_island_period) begin
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    header        <= hdr_d;
                    packet_type   <= hdr_d[7:0];
                    header_ecc_ok <= hdr_ok;
                    sub_ecc_ok    <= sub_ok;
                    packet_valid  <= hdr_ok || !DROP_BAD_HEADER;
                    hdr_q         <= '0;
                    hdr_par_q     <= '0;
                    hdr_ecc_q     <= '0;
                    for (int k = 0; k < 4; k++) begin
                        sub[k]       <= sub_d[k];
                        sub_q[k]     <= '0;
                        sub_par_q[k] <= '0;
                        sub_ecc_q[k] <= '0;
                    end
                end else begin
                    hdr_q     <= hdr_d;
                    hdr_par_q <= hdr_par_d;
                    hdr_ecc_q <= hdr_ecc_d;
                    for (int k = 0; k < 4; k++) begin
                        sub_q[k]     <= sub_d[k];
                        sub_par_q[k] <= sub_par_d[k];
                        sub_ecc_q[k] <= sub_ecc_d[k];
                    end
                end
            end else if (cnt_q != 5'd0) begin
                // Island ended mid-packet: discard partial state, leave outputs intact.
                packet_abort <= 1'b1;
                cnt_q        <= '0;
                hdr_q        <= '0;
                hdr_par_q    <= '0;
                hdr_ecc_q    <= '0;
                for (int k = 0; k < 4; k++) begin
                    sub_q[k]     <= '0;
                    sub_par_q[k] <= '0;
                    sub_ecc_q[k] <= '0;
                end
            end
        end
    end

endmodule
